// File: rtl/wisc_pkg.sv
// Shared WISC-S25 definitions: datapath widths, opcode constants and the
// fetch-stage state encoding. Decode imports the same opcode constants.
package wisc_pkg;

  localparam int INSTR_W = 16;
  localparam int ADDR_W  = 16;

  localparam logic [3:0] OPC_HLT = 4'hF;

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_HOLD    = 2'd1,
    ST_DISCARD = 2'd2,
    ST_HALTED  = 2'd3
  } fetch_state_t;

  function automatic logic [3:0] opcode_of(input logic [INSTR_W-1:0] instr);
    return instr[INSTR_W-1:INSTR_W-4];
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response channel between fetch and the
// instruction memory/cache. The fetch side is the master.
interface fetch_stage_if
  import wisc_pkg::*;
();

  logic               req;
  logic [ADDR_W-1:0]  addr;
  logic               valid;
  logic [INSTR_W-1:0] rdata;

  modport master (output req, output addr, input valid, input rdata);
  modport slave  (input req, input addr, output valid, output rdata);

endinterface

// File: rtl/fetch_stage_pc_incr.sv
// 16-bit PC+2 adder, modulo 2^16 (0xFFFE + 2 wraps to 0x0000, no carry out).
// Shared by the sequential-fetch path and the branch-base computation.
module pc_incr
  import wisc_pkg::*;
(
  input  logic [ADDR_W-1:0] a,
  output logic [ADDR_W-1:0] sum
);

  assign sum = a + ADDR_W'(2);

endmodule

// File: rtl/fetch_stage.sv
// WISC-S25 instruction-fetch stage: owns the PC, requests words from a
// variable-latency instruction memory and fills the IF/ID register.
// Handles stall, branch redirect/flush, in-flight response discard and HLT.
// Optional build macro FETCH_PERF_CNT_EN adds saturating perf counters
// perf_fetch_cnt and perf_stall_cnt.
//
//  state      | meaning
//  -----------+------------------------------------------------------------
//  ST_FETCH   | request at imem.addr (PC) outstanding or being answered
//  ST_HOLD    | word arrived under stall; parked in skip buffer, no request
//  ST_DISCARD | redirected while a request was in flight; drop its response
//  ST_HALTED  | HLT fetched; no requests until a branch squashes it
module fetch_stage
  import wisc_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC   = 16'h0000,
  parameter logic [3:0]        HLT_OPCODE = OPC_HLT
) (
  input  logic               clk,
  input  logic               rst,
  fetch_stage_if.master      imem,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [ADDR_W-1:0]  ifid_pc_next,
  output logic               ifid_valid,
  output logic               halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        perf_fetch_cnt,
  output logic [31:0]        perf_stall_cnt
`endif
);

  fetch_state_t       state;
  logic [ADDR_W-1:0]  pc;
  logic [ADDR_W-1:0]  addr;
  logic               req;
  logic [INSTR_W-1:0] hold_word;
  logic [ADDR_W-1:0]  pc_plus2;

  logic               resp;
  logic               outstanding;
  logic               wr_en;
  logic               wr_hlt;
  logic [INSTR_W-1:0] wr_word;

  pc_incr u_pc_incr (
    .a   (pc),
    .sum (pc_plus2)
  );

  // addr is kept separate from pc so DISCARD can hold the stale address
  // while pc already points at the branch target.
  assign imem.req  = req;
  assign imem.addr = addr;

  // Decode this cycle's IF/ID write and whether a request is still in flight.
  always_comb begin
    resp        = (state == ST_FETCH) && req && imem.valid;
    outstanding = ((state == ST_FETCH) && req && !imem.valid) || (state == ST_DISCARD);
    wr_word     = (state == ST_HOLD) ? hold_word : imem.rdata;
    wr_en       = !branch_taken && !stall && (resp || (state == ST_HOLD));
    wr_hlt      = wr_en && (opcode_of(wr_word) == HLT_OPCODE);
  end

  // Fetch FSM, PC, request and IF/ID register; branch beats everything but reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_FETCH;
      pc           <= RESET_PC;
      addr         <= RESET_PC;
      req          <= 1'b0;
      hold_word    <= '0;
      ifid_instr   <= '0;
      ifid_pc_next <= '0;
      ifid_valid   <= 1'b0;
      halted       <= 1'b0;
    end else if (branch_taken) begin
      ifid_valid <= 1'b0;
      pc         <= branch_target;
      halted     <= 1'b0;
      req        <= 1'b1;
      if (outstanding) begin
        state <= ST_DISCARD;
      end else begin
        state <= ST_FETCH;
        addr  <= branch_target;
      end
    end else if (wr_en) begin
      ifid_instr   <= wr_word;
      ifid_pc_next <= pc_plus2;
      ifid_valid   <= 1'b1;
      if (wr_hlt) begin
        state  <= ST_HALTED;
        halted <= 1'b1;
        req    <= 1'b0;
      end else begin
        state <= ST_FETCH;
        pc    <= pc_plus2;
        addr  <= pc_plus2;
        req   <= 1'b1;
      end
    end else begin
      case (state)
        ST_FETCH: begin
          req <= 1'b1;
          if (resp) begin
            // only reachable with stall=1: park the word and stop requesting
            hold_word <= imem.rdata;
            state     <= ST_HOLD;
            req       <= 1'b0;
          end else if (!stall) begin
            ifid_valid <= 1'b0;
          end
        end
        ST_DISCARD: begin
          if (imem.valid) begin
            state <= ST_FETCH;
            addr  <= pc;
          end
        end
        ST_HOLD, ST_HALTED: begin
        end
        default: state <= ST_FETCH;
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // Saturating counters of live IF/ID writes and of stalled cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (wr_en && (perf_fetch_cnt != 32'hFFFF_FFFF))
        perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if ((stall || (state == ST_HOLD)) && (perf_stall_cnt != 32'hFFFF_FFFF))
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule
